// File: rtl/ets_strobe_gen.sv
// Equivalent-time-sampling strobe generator: frames of cfg_period cycles with per-channel strobes whose delay
// advances by cfg_step each frame. All outputs are registered; frame 0 starts 2 cycles after start; there is no backpressure.
module ets_strobe_gen #(
    parameter int CNT_W   = 16,
    parameter int NCH     = 2,
    parameter int CH_SKEW = 0,
    parameter int IDX_W   = 10
) (
    input  logic             clk_400M,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_step,
    input  logic [IDX_W-1:0] cfg_steps,
    input  logic [CNT_W-1:0] cfg_pulse_w,
    input  logic             cfg_continuous,
    output logic [NCH-1:0]   samp_strobe,
    output logic             frame_clk,
    output logic             frame_start,
    output logic [IDX_W-1:0] step_idx,
    output logic             sweep_done,
    output logic             busy,
    output logic             cfg_err
);

    localparam int XW = CNT_W + 32;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_SWEEP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [IDX_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic             cont_q, cont_d;
    logic             err_q, err_d;

    logic [NCH-1:0]   strobe_q, strobe_d;
    logic             frame_clk_q, frame_clk_d;
    logic             frame_start_q, frame_start_d;
    logic [IDX_W-1:0] step_idx_q, step_idx_d;
    logic             sweep_done_q, sweep_done_d;
    logic             busy_q, busy_d;

    logic             cfg_ok;
    logic [CNT_W:0]   acc_sum;
    logic             in_sweep_n;
    logic [CNT_W-1:0] pw_eff;
    logic [NCH-1:0]   hit;

    assign cfg_ok     = (cfg_period >= CNT_W'(2)) && (cfg_steps != '0);
    assign acc_sum    = {1'b0, acc_q} + {1'b0, step_q};
    assign in_sweep_n = (state_d == S_SWEEP);
    assign pw_eff     = (pw_q == '0) ? CNT_W'(1) : pw_q;

    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            fcnt_q        <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            per_q         <= '0;
            step_q        <= '0;
            steps_q       <= '0;
            pw_q          <= '0;
            cont_q        <= 1'b0;
            err_q         <= 1'b0;
            strobe_q      <= '0;
            frame_clk_q   <= 1'b0;
            frame_start_q <= 1'b0;
            step_idx_q    <= '0;
            sweep_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            per_q         <= per_d;
            step_q        <= step_d;
            steps_q       <= steps_d;
            pw_q          <= pw_d;
            cont_q        <= cont_d;
            err_q         <= err_d;
            strobe_q      <= strobe_d;
            frame_clk_q   <= frame_clk_d;
            frame_start_q <= frame_start_d;
            step_idx_q    <= step_idx_d;
            sweep_done_q  <= sweep_done_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        per_d   = per_q;
        step_d  = step_q;
        steps_d = steps_q;
        pw_d    = pw_q;
        cont_d  = cont_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    if (cfg_ok) begin
                        state_d = S_ARM;
                        per_d   = cfg_period;
                        step_d  = cfg_step;
                        steps_d = cfg_steps;
                        pw_d    = cfg_pulse_w;
                        cont_d  = cfg_continuous;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SWEEP;
                    fcnt_d  = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_SWEEP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (fcnt_q == per_q - CNT_W'(1)) begin
                    fcnt_d = '0;
                    if (idx_q == steps_q - IDX_W'(1)) begin
                        if (cont_q) begin
                            idx_d = '0;
                            acc_d = '0;
                            ovf_d = 1'b0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        acc_d = acc_sum[CNT_W-1:0];
                        // Once the delay wraps it stays invalid for the rest of the sweep.
                        ovf_d = ovf_q | acc_sum[CNT_W];
                    end
                end else begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [XW-1:0] SKEW = XW'(c * CH_SKEW);
        logic [XW-1:0] dc;
        logic [XW-1:0] rel;
        assign dc     = XW'(acc_d) + SKEW;
        assign rel    = XW'(fcnt_d) - dc;
        // The fcnt range itself truncates a strobe at the frame end.
        assign hit[c] = !ovf_d && (dc < XW'(per_q)) && (XW'(fcnt_d) >= dc) && (rel < XW'(pw_eff));
    end

    always_comb begin
        strobe_d      = in_sweep_n ? hit : '0;
        frame_start_d = in_sweep_n && (fcnt_d == '0);
        frame_clk_d   = in_sweep_n && (fcnt_d < (per_q >> 1));
        step_idx_d    = in_sweep_n ? idx_d : '0;
        sweep_done_d  = in_sweep_n && (fcnt_d == per_q - CNT_W'(1)) &&
                        (idx_d == steps_q - IDX_W'(1));
        busy_d        = (state_d == S_ARM) || in_sweep_n;
    end

    assign samp_strobe = strobe_q;
    assign frame_clk   = frame_clk_q;
    assign frame_start = frame_start_q;
    assign step_idx    = step_idx_q;
    assign sweep_done  = sweep_done_q;
    assign busy        = busy_q;
    assign cfg_err     = err_q;

endmodule
